// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared widths and FSM state type for the data memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_word_ram.sv
`default_nettype none
// ============================================================================
// Module  : mem_word_ram
// Brief   : Synchronous single-port word array with per-byte write enables.
//           A write returns the merged new word on the same access.
// Revision: 1.0 - initial release
// ============================================================================
module mem_word_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Per-lane write and read-back; written lanes return the new byte.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
          rdata_q[8*i +: 8]    <= wdata[8*i +: 8];
        end else begin
          rdata_q[8*i +: 8]    <= mem_q[idx][8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Valid/ready memory responder with configurable wait states,
//           address error checking and byte-enabled writes.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              live_q, live_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rd_sel_q, rd_sel_d;

  logic              accept;
  logic              acc_fire;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic [DATA_W-1:0] ram_rdata;

  // Access-side selection: with zero wait states the access happens on the
  // accept edge straight from the request bus, otherwise from the latch.
  always_comb begin
    accept    = req_valid && req_ready;
    acc_fire  = (ZERO_WAIT && accept) || ((state_q == WAIT) && (cnt_q == '0));
    acc_we    = (state_q == IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_be    = (state_q == IDLE) ? req_be    : be_q;
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                (32'(acc_addr[ADDR_W-1:2]) >= 32'(DEPTH_WORDS));
  end

  // Next-state, request latch and response flag computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    live_d    = 1'b1;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rsp_err_d = rsp_err_q;
    rd_sel_d  = rd_sel_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (ZERO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
          rd_sel_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response flags are captured on the same edge the storage is accessed.
    if (acc_fire) begin
      rsp_err_d = acc_err;
      rd_sel_d  = !acc_we && !acc_err;
    end
  end

  // State and response registers; storage itself is not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      live_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_err_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      live_q    <= live_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rsp_err_q <= rsp_err_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  mem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (acc_fire),
    .we    (acc_we && !acc_err),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (ram_rdata)
  );

  // Read data is only passed through for a successful read; writes and
  // rejected requests present zero.
  assign req_ready = live_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Self-checking bench for data_mem_responder; three instances with
//           different wait-state / depth settings share one request bus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [1:0]  sel;

  logic [2:0]  rv, rr_w, vv_w, er_w;
  logic [31:0] rd0_w, rd1_w, rd2_w;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  logic [31:0] exp_rdata;
  logic        exp_err;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_v = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          inst;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          hold;
  } vec_t;
  vec_t vecs[21];

  always #5 clk = ~clk;

  assign rv[0] = req_valid && (sel == 2'd0);
  assign rv[1] = req_valid && (sel == 2'd1);
  assign rv[2] = req_valid && (sel == 2'd2);

  data_mem_responder #(.WAIT_CYCLES(1), .DEPTH_WORDS(2048)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vv_w[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd0_w), .rsp_err(er_w[0]));

  data_mem_responder #(.WAIT_CYCLES(3), .DEPTH_WORDS(1024)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vv_w[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd1_w), .rsp_err(er_w[1]));

  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rr_w[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vv_w[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd2_w), .rsp_err(er_w[2]));

  // Route the selected instance onto the observed response bus.
  always_comb begin
    req_ready_m = rr_w[sel];
    rsp_valid_m = vv_w[sel];
    rsp_err_m   = er_w[sel];
    case (sel)
      2'd0:    rsp_rdata_m = rd0_w;
      2'd1:    rsp_rdata_m = rd1_w;
      default: rsp_rdata_m = rd2_w;
    endcase
  end

  function automatic int lat_of(input logic [1:0] s);
    case (s)
      2'd0:    return 2;
      2'd1:    return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, check latency on rise, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready_m) begin
        exp_t e;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
      if (rsp_valid_m && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1'b0, 32'd1, 32'd0);
        else chk("latency", (cyc - sb[0].acc_cyc) == lat_of(sel),
                 32'(cyc - sb[0].acc_cyc), 32'(lat_of(sel)));
      end
      if (rsp_valid_m && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_without_req", 1'b0, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata_m === e.rdata, rsp_rdata_m, e.rdata);
          chk("rsp_err", rsp_err_m === e.err, 32'(rsp_err_m), 32'(e.err));
        end
      end
    end
    prev_v = rsp_valid_m;
  end

  task automatic wait_accept(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = req_ready_m;
    end
    if (!got) chk("accept_timeout", 1'b0, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = rsp_valid_m;
    end
    if (!got) chk("rsp_timeout", 1'b0, 32'd0, 32'd1);
  endtask

  // One complete transfer; called just after a rising edge.
  task automatic txn(input bit we, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] erd, input bit eerr, input int hold);
    bit got;
    logic [31:0] rd0;
    logic er0;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    exp_rdata = erd; exp_err = eerr;
    req_valid = 1'b1;
    wait_accept(got);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = 16'hFFFF; req_wdata = 32'hFFFF_FFFF; req_we = ~we;
    if (!got) return;
    wait_rsp(got);
    if (!got) return;
    rd0 = rsp_rdata_m;
    er0 = rsp_err_m;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", rsp_valid_m && !req_ready_m && rsp_rdata_m === rd0 && rsp_err_m === er0,
          rsp_rdata_m, rd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_hs", !rsp_valid_m && req_ready_m, {30'd0, rsp_valid_m, req_ready_m}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int acc[4];

    vecs[0]  = '{0, 1'b1, 16'h1000, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0};
    vecs[1]  = '{0, 1'b0, 16'h1000, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1};
    vecs[2]  = '{0, 1'b1, 16'h0010, 32'h11223344, 4'hF, 32'h0,        1'b0, 0};
    vecs[3]  = '{0, 1'b1, 16'h0010, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2};
    vecs[4]  = '{0, 1'b0, 16'h0010, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 5};
    vecs[5]  = '{0, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 0};
    vecs[6]  = '{0, 1'b0, 16'h0010, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 0};
    vecs[7]  = '{0, 1'b0, 16'h0002, 32'h0,        4'hF, 32'h0,        1'b1, 2};
    vecs[8]  = '{0, 1'b1, 16'h0012, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0};
    vecs[9]  = '{0, 1'b0, 16'h0010, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 0};
    vecs[10] = '{0, 1'b0, 16'h2000, 32'h0,        4'hF, 32'h0,        1'b1, 0};
    vecs[11] = '{0, 1'b1, 16'h1FFC, 32'h12345678, 4'hF, 32'h0,        1'b0, 0};
    vecs[12] = '{0, 1'b0, 16'h1FFC, 32'h0,        4'h0, 32'h12345678, 1'b0, 1};
    vecs[13] = '{1, 1'b1, 16'h0000, 32'h01010101, 4'hF, 32'h0,        1'b0, 0};
    vecs[14] = '{1, 1'b1, 16'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 0};
    vecs[15] = '{1, 1'b0, 16'h0000, 32'h0,        4'hF, 32'h01010101, 1'b0, 0};
    vecs[16] = '{1, 1'b0, 16'h1000, 32'h0,        4'hF, 32'h0,        1'b1, 3};
    vecs[17] = '{1, 1'b0, 16'h0002, 32'h0,        4'hF, 32'h0,        1'b1, 0};
    vecs[18] = '{1, 1'b1, 16'h0FFC, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0, 0};
    vecs[19] = '{1, 1'b1, 16'h0FFE, 32'h00000000, 4'hF, 32'h0,        1'b1, 0};
    vecs[20] = '{1, 1'b0, 16'h0FFC, 32'h0,        4'hF, 32'h0BADC0DE, 1'b0, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; sel = 2'd0;
    exp_rdata = '0; exp_err = 1'b0;

    // Outputs while reset is held
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("reset_req_ready", req_ready_m === 1'b0, 32'(req_ready_m), 32'd0);
      chk("reset_rsp_valid", rsp_valid_m === 1'b0, 32'(rsp_valid_m), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata_m === 32'd0, rsp_rdata_m, 32'd0);
      chk("reset_rsp_err", rsp_err_m === 1'b0, 32'(rsp_err_m), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("ready_after_release", req_ready_m === 1'b1, 32'(req_ready_m), 32'd1);
    end
    @(posedge clk); #1;

    // Table-driven transfers
    for (int i = 0; i < 21; i++) begin
      sel = 2'(vecs[i].inst);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold);
    end

    // Reset during WAIT of a write discards it (WAIT_CYCLES=3 instance)
    sel = 2'd1;
    txn(1'b1, 16'h0020, 32'h000000AA, 4'hF, 32'h0, 1'b0, 0);
    req_we = 1'b1; req_addr = 16'h0020; req_wdata = 32'h5; req_be = 4'hF;
    exp_rdata = 32'h0; exp_err = 1'b0;
    req_valid = 1'b1;
    wait_accept(got);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready_m === 1'b0, 32'(req_ready_m), 32'd0);
    chk("abort_rsp_valid", rsp_valid_m === 1'b0, 32'(rsp_valid_m), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata_m === 32'd0, rsp_rdata_m, 32'd0);
    chk("abort_rsp_err", rsp_err_m === 1'b0, 32'(rsp_err_m), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 16'h0020, 32'h0, 4'hF, 32'h000000AA, 1'b0, 0);

    // Reset in RESP after the write was performed keeps the new data
    req_we = 1'b1; req_addr = 16'h0024; req_wdata = 32'h77; req_be = 4'hF;
    exp_rdata = 32'h0; exp_err = 1'b0;
    req_valid = 1'b1;
    wait_accept(got);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(got);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", rsp_valid_m === 1'b0, 32'(rsp_valid_m), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 16'h0024, 32'h0, 4'hF, 32'h00000077, 1'b0, 0);

    // Back-to-back reads with zero wait states and rsp_ready held high
    sel = 2'd2;
    for (int k = 0; k < 4; k++)
      txn(1'b1, 16'(16'h0100 + 4*k), 32'hA0000000 + 32'(k), 4'hF, 32'h0, 1'b0, 0);
    rsp_ready = 1'b1;
    req_we = 1'b0; req_be = 4'h0;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = 16'(16'h0100 + 4*k);
      exp_rdata = 32'hA0000000 + 32'(k);
      exp_err = 1'b0;
      wait_accept(got);
      acc[k] = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    chk("b2b_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
    rsp_ready = 1'b0;
    for (int k = 1; k < 4; k++)
      chk("b2b_period", (acc[k] - acc[k-1]) == 2, 32'(acc[k] - acc[k-1]), 32'd2);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
